// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl - parametrised VGA timing generator and framebuffer scan front end.
//
// Purpose: free-running h/v counters, windowed framebuffer read addressing with
// 2^SCALE_LOG2 pixel replication, a blanking-interval write window for
// framebuffer updates, and RGB/sync pins delayed so that read data returned
// RD_LAT clocks after rd_en lands on its own pixel.
//
// Ports:
//   clk, rst                  pixel clock, asynchronous active-high reset
//   test_en                   (VGA_TESTPAT_EN only) show colour bars in window
//   rd_data  [3*RGB_W]        framebuffer pixel {B,G,R}, RD_LAT clocks after rd_en
//   rd_en, rd_x, rd_y         framebuffer read strobe / scaled window address
//   wr_en, wr_x, wr_y         update window strobe / address (horizontal blanking)
//   red, green, blue          pixel colour, zero outside window or when blanked
//   hsync, vsync              sync pins, polarity HS_POL / VS_POL
//   frame_start, line_start   single-clock pulses
//
// Optional feature macro: VGA_TESTPAT_EN (adds test_en and an 8-bar pattern).
module vga_scan_ctrl #(
  parameter int H_VIS      = 800,
  parameter int H_FP       = 56,
  parameter int H_SYNC     = 120,
  parameter int H_BP       = 64,
  parameter int V_VIS      = 600,
  parameter int V_FP       = 37,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 23,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int WIN_X0     = 0,
  parameter int WIN_Y0     = 0,
  parameter int WIN_W      = 800,
  parameter int WIN_H      = 600,
  parameter int SCALE_LOG2 = 2,
  parameter int RGB_W      = 2,
  parameter int RD_LAT     = 1,
  parameter int AX_W       = 8,
  parameter int AY_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
`ifdef VGA_TESTPAT_EN
  input  logic               test_en,
`endif
  input  logic [3*RGB_W-1:0] rd_data,
  output logic               rd_en,
  output logic [AX_W-1:0]    rd_x,
  output logic [AY_W-1:0]    rd_y,
  output logic               wr_en,
  output logic [AX_W-1:0]    wr_x,
  output logic [AY_W-1:0]    wr_y,
  output logic [RGB_W-1:0]   red,
  output logic [RGB_W-1:0]   green,
  output logic [RGB_W-1:0]   blue,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start,
  output logic               line_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int WR_LEN = WIN_W >> SCALE_LOG2;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VISC = HW'(H_VIS);
  localparam logic [HW-1:0] H_SS   = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] H_SL   = HW'(H_SYNC);
  localparam logic [HW-1:0] H_X0   = HW'(WIN_X0);
  localparam logic [HW-1:0] H_WW   = HW'(WIN_W);
  localparam logic [HW-1:0] H_WRL  = HW'(WR_LEN);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VISC = VW'(V_VIS);
  localparam logic [VW-1:0] V_SS   = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] V_SL   = VW'(V_SYNC);
  localparam logic [VW-1:0] V_Y0   = VW'(WIN_Y0);
  localparam logic [VW-1:0] V_WH   = VW'(WIN_H);
  localparam logic [VW-1:0] V_MASK = VW'((1 << SCALE_LOG2) - 1);

  // The update window lives entirely in horizontal blanking.
  if (H_TOT - H_VIS < WR_LEN) begin : g_wr_fit_chk
    $error("vga_scan_ctrl: update window longer than horizontal blanking");
  end

  typedef struct packed {
    logic       vis;
    logic       win;
    logic       hs;
    logic       vs;
`ifdef VGA_TESTPAT_EN
    logic       tp;
    logic [2:0] bar;
`endif
  } flag_t;

  logic [HW-1:0]   h_cnt_q, h_cnt_d, h_rel;
  logic [VW-1:0]   v_cnt_q, v_cnt_d, v_rel;
  logic            in_win, wr_act;
  logic            rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [AX_W-1:0] rd_x_q, rd_x_d, wr_x_q, wr_x_d;
  logic [AY_W-1:0] rd_y_q, rd_y_d, wr_y_q, wr_y_d;
  logic            frame_start_q, frame_start_d, line_start_q, line_start_d;
  flag_t [RD_LAT:0] pipe_q, pipe_d;
  flag_t           p;
  logic [RGB_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic            hsync_q, hsync_d, vsync_q, vsync_d;

  always_comb begin
    h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;

    // Window-relative offsets; a counter left of/above the origin wraps to a
    // large value, so a single unsigned compare covers both window edges.
    h_rel  = h_cnt_q - H_X0;
    v_rel  = v_cnt_q - V_Y0;
    in_win = (h_rel < H_WW) && (v_rel < V_WH);
    wr_act = (v_rel < V_WH) && ((v_rel & V_MASK) == '0) &&
             ((h_cnt_q - H_VISC) < H_WRL);

    rd_en_d = in_win;
`ifdef VGA_TESTPAT_EN
    if (test_en) rd_en_d = 1'b0;
`endif
    rd_x_d  = in_win ? AX_W'(h_rel >> SCALE_LOG2) : rd_x_q;
    rd_y_d  = in_win ? AY_W'(v_rel >> SCALE_LOG2) : rd_y_q;
    wr_en_d = wr_act;
    wr_x_d  = wr_act ? AX_W'(h_cnt_q - H_VISC) : wr_x_q;
    wr_y_d  = wr_act ? AY_W'(v_rel >> SCALE_LOG2) : wr_y_q;
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    line_start_d  = (h_cnt_q == '0);

    // Flag delay line: stage RD_LAT lines up with rd_data of the same pixel.
    pipe_d[0].vis = (h_cnt_q < H_VISC) && (v_cnt_q < V_VISC);
    pipe_d[0].win = in_win;
    pipe_d[0].hs  = (h_cnt_q - H_SS) < H_SL;
    pipe_d[0].vs  = (v_cnt_q - V_SS) < V_SL;
`ifdef VGA_TESTPAT_EN
    pipe_d[0].tp  = test_en;
    pipe_d[0].bar = 3'((int'(rd_x_d) * 8) / WR_LEN);
`endif
    for (int i = 1; i <= RD_LAT; i++) pipe_d[i] = pipe_q[i-1];

    p       = pipe_q[RD_LAT];
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (p.vis && p.win) begin
      red_d   = rd_data[RGB_W-1:0];
      green_d = rd_data[2*RGB_W-1:RGB_W];
      blue_d  = rd_data[3*RGB_W-1:2*RGB_W];
`ifdef VGA_TESTPAT_EN
      if (p.tp) begin
        red_d   = {RGB_W{p.bar[0]}};
        green_d = {RGB_W{p.bar[1]}};
        blue_d  = {RGB_W{p.bar[2]}};
      end
`endif
    end
    hsync_d = p.hs ? HS_POL : ~HS_POL;
    vsync_d = p.vs ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      rd_en_q       <= 1'b0;
      rd_x_q        <= '0;
      rd_y_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_x_q        <= '0;
      wr_y_q        <= '0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      pipe_q        <= '0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      rd_en_q       <= rd_en_d;
      rd_x_q        <= rd_x_d;
      rd_y_q        <= rd_y_d;
      wr_en_q       <= wr_en_d;
      wr_x_q        <= wr_x_d;
      wr_y_q        <= wr_y_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      pipe_q        <= pipe_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_x        = rd_x_q;
  assign rd_y        = rd_y_q;
  assign wr_en       = wr_en_q;
  assign wr_x        = wr_x_q;
  assign wr_y        = wr_y_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;

endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

Parametrised VGA scan controller: generates horizontal/vertical timing for any mode, active-window framebuffer read addressing with power-of-two pixel replication, a blanking-interval write window for framebuffer updates, and pipeline-aligned RGB/sync outputs that compensate for framebuffer read latency. Sits between the pixel-clock domain and the framebuffer RAM, driving the board VGA connector. Default parameters give 800x600@72 Hz from a 50 MHz clock.

## Interface
- H_VIS, 800, visible pixels per line
- H_FP / H_SYNC / H_BP, 56 / 120 / 64, horizontal front porch / sync / back porch (clocks)
- V_VIS, 600, visible lines per frame
- V_FP / V_SYNC / V_BP, 37 / 6 / 23, vertical front porch / sync / back porch (lines)
- HS_POL / VS_POL, 1 / 1, active sync level
- WIN_X0 / WIN_Y0, 0 / 0, window origin inside visible area (pixels)
- WIN_W / WIN_H, 800 / 600, window size (pixels; multiples of 2^SCALE_LOG2)
- SCALE_LOG2, 2, pixel replication factor = 2^SCALE_LOG2 in both axes
- RGB_W, 2, bits per colour channel
- RD_LAT, 1, framebuffer read latency in clocks (>= 1)
- AX_W / AY_W, 8 / 8, framebuffer column/row address widths
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- rd_data  in  3*RGB_W  framebuffer pixel {B,G,R}, valid RD_LAT clocks after rd_en
- rd_en  out  1  framebuffer read strobe
- rd_x / rd_y  out  AX_W / AY_W  read address (window-relative, scaled)
- wr_en  out  1  update window open
- wr_x / wr_y  out  AX_W / AY_W  update address
- red / green / blue  out  RGB_W each  pixel output, zero when blanked
- hsync / vsync  out  1  sync outputs
- frame_start / line_start  out  1  single-clock pulses

## Operation
- h_cnt 0..H_TOT-1 (H_TOT = H_VIS+H_FP+H_SYNC+H_BP), increments every clock, wraps to 0; v_cnt 0..V_TOT-1 increments on h_cnt wrap, wraps to 0 after V_TOT-1.
- Visible: h_cnt < H_VIS and v_cnt < V_VIS. Sync active: H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC (same for vertical).
- In window: WIN_X0 <= h_cnt < WIN_X0+WIN_W and WIN_Y0 <= v_cnt < WIN_Y0+WIN_H. rd_en = in window; rd_x = (h_cnt-WIN_X0)>>SCALE_LOG2, rd_y = (v_cnt-WIN_Y0)>>SCALE_LOG2, truncated to AX_W/AY_W. Outside window rd_x/rd_y hold last value.
- Pixels visible but outside window output zero colour.
- Update window: on lines with v_cnt in window rows where (v_cnt-WIN_Y0) mod 2^SCALE_LOG2 == 0, wr_en asserts from h_cnt = H_VIS for WIN_W>>SCALE_LOG2 clocks; wr_x counts 0 upward, wr_y = current scaled row. Requires H_TOT-H_VIS >= WIN_W>>SCALE_LOG2 (checked by elaboration-time assertion). rd_en and wr_en never both high.
- frame_start pulses when h_cnt=0, v_cnt=0; line_start when h_cnt=0.
- Reset mid-frame: counters return to 0 immediately, all pipeline stages cleared; first frame_start one clock after release.

## Timing
- Reset values: counters 0; rd_en, wr_en, frame_start, line_start 0; rd_x, rd_y, wr_x, wr_y 0; red/green/blue 0; hsync = !HS_POL, vsync = !VS_POL.
- rd_en, rd_x/rd_y, wr_en, wr_x/wr_y, frame_start, line_start registered: valid 1 clock after the counter value they decode.
- Visible/window/sync flags pass through an (RD_LAT+1)-stage delay line; red/green/blue/hsync/vsync registered from it, so counter-to-pin latency = RD_LAT+2 clocks and rd_data sampled for a read is output exactly on its own pixel.

## Configuration
- VGA_TESTPAT_EN: when defined, adds input test_en (1 bit); with test_en=1 window pixels show 8 vertical colour bars ({B,G,R} = bar index 0..7 replicated to RGB_W bits, bar = rd_x * 8 / (WIN_W>>SCALE_LOG2)), rd_en forced 0, wr_en unaffected. Undefined: port absent, rd_data always used.

## Test plan
- Sim params H 8/2/3/3, V 4/1/2/1, SCALE_LOG2=0, RD_LAT=1: after reset release hsync high for h_cnt 10..12 seen on pin at clocks 13..15 of each line; line period 16, frame period 128 clocks.
- Same params, rd_data = rd_x echoed: pins show colour 0..7 on visible pixels, 0 in blanking, aligned with no pixel offset.
- SCALE_LOG2=1, WIN 4x2 at origin (2,1): rd_x sequence 0,0,1,1 on lines 1,2 only; rd_y 0 both lines; pixels outside window zero.
- Update window with SCALE_LOG2=1: wr_en 2 clocks from h_cnt=8 on line 1 only, wr_x 0,1, wr_y 0; never overlaps rd_en.
- Assert rst at h_cnt=5, v_cnt=2: all outputs at reset values same clock; after release frame_start pulses once, next after 128 clocks.
- VGA_TESTPAT_EN defined, test_en=1, WIN_W=8: pins show 0..7 across line, rd_en stays 0.
